demorgan_sweep_checker: RTL and testbench
=========================================

// Module: demorgan_sweep_checker
// PURPOSE
//   Parametrised, self-sequencing De Morgan checker. On start it sweeps every {A,B} pair of
//   WIDTH-bit operands and evaluates both identities bitwise: ~A&~B == ~(A|B), ~(A&B) == ~A|~B.
//   Each row streams out over a valid/ready channel. Mismatches are counted and the first
//   failing row is captured. Replaces the hand-stepped 1-bit truth-table bench.
// PARAMETERS
//   WIDTH   2   operand width in bits (1..8); sweep length N = 2**(2*WIDTH) rows
// PORTS
//   clk             in   1        rising-edge clock
//   rst_n           in   1        asynchronous active-low reset
//   start           in   1        sweep request, sampled in IDLE/DONE only
//   fault_en        in   1        fault injection, sampled at start and held for the sweep
//   busy            out  1        high in RUN
//   done            out  1        high in DONE, held until next accepted start
//   pass            out  1        valid when done=1; 1 iff mismatch_count==0
//   mismatch_count  out  2W+1     rows failing either identity
//   first_fail_idx  out  2W       sweep index of first failing row
//   first_fail_vld  out  1        first_fail_idx holds a captured value
//   row_valid       out  1        row_* outputs carry a row
//   row_ready       in   1        consumer accepts row when row_valid&row_ready
//   row_a           out  W        operand A = idx[2W-1:W]
//   row_b           out  W        operand B = idx[W-1:0]
//   row_lhs1        out  W        ~A & ~B
//   row_rhs1        out  W        ~(A|B), with fault applied
//   row_lhs2        out  W        ~(A&B)
//   row_rhs2        out  W        ~A | ~B
//   row_ok          out  1        (lhs1==rhs1)&&(lhs2==rhs2)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, idx=0. All outputs are 0 except row_a/row_b, which
//     reflect idx=0 and may be nonzero in width only. Reset mid-sweep aborts the sweep with
//     no partial result retained.
//   FSM states: IDLE, RUN, DONE.
//     IDLE --start--> RUN: idx<=0, mismatch_count<=0, first_fail_vld<=0, fault latched.
//     RUN: row_valid=1. Row fields are combinational from registered idx.
//       On handshake: if !row_ok, mismatch_count++. If also !first_fail_vld, capture
//         first_fail_idx<=idx and set first_fail_vld.
//       If idx==N-1 at handshake: go to DONE. Otherwise idx++.
//       With row_ready=0, idx and all row fields hold stable. No row is dropped or repeated.
//     DONE: done=1, busy=0, row_valid=0; results hold. start: same action as from IDLE.
//   start is ignored in RUN; no restart or queuing.
//   Latency: start high at edge k gives row_valid=1 from edge k+1.
//     With row_ready tied high, a sweep takes N cycles. done rises at edge k+N+1.
//   Fault: when latched fault_en=1 and idx[0]=1, rhs1 bit0 is inverted.
//     This gives N/2 mismatches, and the first failure is at idx=1.
//   mismatch_count is 2W+1 bits so the value N is representable; no saturation needed.
//   pass = done & (mismatch_count==0); pass is 0 outside DONE.
// TESTING
//   T1: WIDTH=1, start pulse, row_ready=1 -> 4 rows (A,B)=00,01,10,11;
//       lhs1=rhs1=1,0,0,0; lhs2=rhs2=1,1,1,0; done after 4 rows; pass=1, count=0.
//   T2: WIDTH=2, fault_en=1, ready=1 -> 16 rows; count=8; first_fail_idx=1;
//       first_fail_vld=1; pass=0.
//   T3: WIDTH=2, row_ready toggling with random stalls -> exactly 16 handshakes;
//       idx order 0..15 with no gaps or repeats; row fields stable while stalled.
//   T4: rst_n low at row 5 of a WIDTH=2 sweep -> all outputs 0 immediately.
//       Next start runs a full clean sweep: pass=1, count=0.
//   T5: start pulsed during RUN, then again in DONE -> first pulse has no effect.
//       Second pulse clears results and begins a new sweep the next cycle.
//   T6: WIDTH=4, ready=1 -> done after 256 cycles; count=0; pass=1;
//       sweep ends with row_a=row_b=4'hF.

Source files
------------

// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker
//   Self-sequencing De Morgan checker. A start request sweeps every {A,B} pair of
//   WIDTH-bit operands, checking ~A&~B == ~(A|B) and ~(A&B) == ~A|~B bitwise.
//   Each row is offered on a valid/ready stream. Failing rows are counted, and the
//   index of the first failing row is captured.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               sweep request, honoured only in idle/done
//   fault_en            latched at start; flips rhs1 bit 0 on odd indices
//   busy, done, pass    sweep status; pass is meaningful only while done
//   mismatch_count      number of failing rows (2*WIDTH+1 bits, can hold N)
//   first_fail_idx/vld  index of first failing row and its valid flag
//   row_valid/ready     row stream handshake
//   row_a, row_b        operands decoded from the sweep index
//   row_lhs1..row_rhs2  both sides of both identities
//   row_ok              row satisfies both identities
module demorgan_sweep_checker #(
  parameter int unsigned WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               fault_en,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   mismatch_count,
  output logic [2*WIDTH-1:0] first_fail_idx,
  output logic               first_fail_vld,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [WIDTH-1:0]   row_a,
  output logic [WIDTH-1:0]   row_b,
  output logic [WIDTH-1:0]   row_lhs1,
  output logic [WIDTH-1:0]   row_rhs1,
  output logic [WIDTH-1:0]   row_lhs2,
  output logic [WIDTH-1:0]   row_rhs2,
  output logic               row_ok
);

  localparam int unsigned IdxW = 2 * WIDTH;
  localparam logic [IdxW-1:0] LastIdx = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              fault_q;
  logic [IdxW:0]     cnt_q;
  logic [IdxW-1:0]   ffi_q;
  logic              ffv_q;

  logic [WIDTH-1:0]  a, b, lhs1, rhs1, lhs2, rhs2, fault_mask;
  logic              ok, running;

  always_comb begin
    a          = idx_q[IdxW-1:WIDTH];
    b          = idx_q[WIDTH-1:0];
    fault_mask = '0;
    fault_mask[0] = fault_q & idx_q[0];
    lhs1       = ~a & ~b;
    rhs1       = ~(a | b) ^ fault_mask;
    lhs2       = ~(a & b);
    rhs2       = ~a | ~b;
    ok         = (lhs1 == rhs1) && (lhs2 == rhs2);
    running    = (state_q == StRun);
  end

  // Row result fields read zero outside a sweep so reset leaves every output low.
  always_comb begin
    busy           = running;
    done           = (state_q == StDone);
    pass           = (state_q == StDone) && (cnt_q == '0);
    mismatch_count = cnt_q;
    first_fail_idx = ffi_q;
    first_fail_vld = ffv_q;
    row_valid      = running;
    row_a          = a;
    row_b          = b;
    row_lhs1       = running ? lhs1 : '0;
    row_rhs1       = running ? rhs1 : '0;
    row_lhs2       = running ? lhs2 : '0;
    row_rhs2       = running ? rhs2 : '0;
    row_ok         = running & ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            idx_q   <= '0;
            cnt_q   <= '0;
            ffv_q   <= 1'b0;
            fault_q <= fault_en;
          end
        end
        StRun: begin
          if (row_ready) begin
            if (!ok) begin
              cnt_q <= cnt_q + 1'b1;
              if (!ffv_q) begin
                ffi_q <= idx_q;
                ffv_q <= 1'b1;
              end
            end
            // The last index is held in done so the final row stays visible.
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Scoreboard bench: three instances (WIDTH 1, 2, 4) share stimulus, one selected at a time.
module tb_demorgan_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, fault_en, row_ready;
  int   sel;

  logic        o_busy[3], o_done[3], o_pass[3], o_ffv[3], o_valid[3], o_ok[3];
  logic [16:0] o_cnt[3];
  logic [15:0] o_ffi[3];
  logic [7:0]  o_a[3], o_b[3], o_l1[3], o_r1[3], o_l2[3], o_r2[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = 1 << g;
    logic           busy, done, pass, ffv, valid, ok;
    logic [2*W:0]   cnt;
    logic [2*W-1:0] ffi;
    logic [W-1:0]   a, b, l1, r1, l2, r2;

    demorgan_sweep_checker #(.WIDTH(W)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start && (sel == g)),
      .fault_en       (fault_en),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .mismatch_count (cnt),
      .first_fail_idx (ffi),
      .first_fail_vld (ffv),
      .row_valid      (valid),
      .row_ready      (row_ready),
      .row_a          (a),
      .row_b          (b),
      .row_lhs1       (l1),
      .row_rhs1       (r1),
      .row_lhs2       (l2),
      .row_rhs2       (r2),
      .row_ok         (ok)
    );

    assign o_busy[g]  = busy;
    assign o_done[g]  = done;
    assign o_pass[g]  = pass;
    assign o_ffv[g]   = ffv;
    assign o_valid[g] = valid;
    assign o_ok[g]    = ok;
    assign o_cnt[g]   = 17'(cnt);
    assign o_ffi[g]   = 16'(ffi);
    assign o_a[g]     = 8'(a);
    assign o_b[g]     = 8'(b);
    assign o_l1[g]    = 8'(l1);
    assign o_r1[g]    = 8'(r1);
    assign o_l2[g]    = 8'(l2);
    assign o_r2[g]    = 8'(r2);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard state: expected rows in sweep order plus expected sweep summary.
  logic [48:0] exp_q[$];
  int exp_n, exp_cnt, exp_ffi, hs;
  logic [48:0] held;
  bit held_v = 1'b0;

  function automatic logic [48:0] cur_row();
    return {o_a[sel], o_b[sel], o_l1[sel], o_r1[sel], o_l2[sel], o_r2[sel], o_ok[sel]};
  endfunction

  // Reference: evaluate both identities on integer operands for every pair.
  task automatic load_model(int w, bit f);
    int n, mask, a, b, l1, r1, l2, r2;
    bit ok;
    n = 1 << (2 * w);
    mask = (1 << w) - 1;
    exp_n = n;
    exp_cnt = 0;
    exp_ffi = 0;
    for (int i = 0; i < n; i++) begin
      a  = i / (1 << w);
      b  = i % (1 << w);
      l1 = (~a) & (~b) & mask;
      r1 = (~(a | b)) & mask;
      if (f && (i % 2 == 1)) r1 = r1 ^ 1;
      l2 = (~(a & b)) & mask;
      r2 = ((~a) | (~b)) & mask;
      ok = (l1 == r1) && (l2 == r2);
      if (!ok) begin
        if (exp_cnt == 0) exp_ffi = i;
        exp_cnt++;
      end
      exp_q.push_back({a[7:0], b[7:0], l1[7:0], r1[7:0], l2[7:0], r2[7:0], ok});
    end
  endtask

  // Monitor: inputs change #1 after posedge, so negedge sees what the next posedge takes.
  always @(negedge clk) begin
    if (rst_n && o_valid[sel]) begin
      if (held_v) chk("stall_hold", 64'(cur_row()), 64'(held));
      if (row_ready) begin
        hs++;
        if (exp_q.size() == 0) chk("extra_row", 64'(exp_q.size()), 64'd1);
        else chk($sformatf("row%0d", hs - 1), 64'(cur_row()), 64'(exp_q.pop_front()));
        held_v = 1'b0;
      end else begin
        held   = cur_row();
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"},  64'(o_busy[sel]),  64'd0);
    chk({tag, "_done"},  64'(o_done[sel]),  64'd0);
    chk({tag, "_pass"},  64'(o_pass[sel]),  64'd0);
    chk({tag, "_valid"}, 64'(o_valid[sel]), 64'd0);
    chk({tag, "_cnt"},   64'(o_cnt[sel]),   64'd0);
    chk({tag, "_ffv"},   64'(o_ffv[sel]),   64'd0);
    chk({tag, "_ffi"},   64'(o_ffi[sel]),   64'd0);
    chk({tag, "_row"},   64'(cur_row()),    64'd0);
  endtask

  // Issue start at the next edge; model rows are queued only if the start is honoured.
  task automatic begin_sweep(int s, bit f, bit accept);
    @(posedge clk); #1;
    sel = s;
    fault_en = f;
    start = 1'b1;
    if (accept) begin
      load_model(1 << s, f);
      hs = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_sweep(bit stall, output int cyc);
    cyc = 0;
    while (!o_done[sel] && cyc < 5000) begin
      row_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!o_done[sel]) chk("timeout", 64'(cyc), 64'd0);
    chk("done",       64'(o_done[sel]),  64'd1);
    chk("busy_low",   64'(o_busy[sel]),  64'd0);
    chk("valid_low",  64'(o_valid[sel]), 64'd0);
    chk("count",      64'(o_cnt[sel]),   64'(exp_cnt));
    chk("pass",       64'(o_pass[sel]),  64'(exp_cnt == 0));
    chk("ffv",        64'(o_ffv[sel]),   64'(exp_cnt != 0));
    if (exp_cnt != 0) chk("ffi", 64'(o_ffi[sel]), 64'(exp_ffi));
    chk("rows_left",  64'(exp_q.size()), 64'd0);
    chk("handshakes", 64'(hs),           64'(exp_n));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; fault_en = 1'b0; row_ready = 1'b0; sel = 0; hs = 0;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 check_all_zero("reset");
    end
    #20 rst_n = 1'b1;

    // T1: WIDTH=1 clean sweep, 4 rows in 4 cycles.
    begin_sweep(0, 1'b0, 1'b1);
    finish_sweep(1'b0, cyc);
    chk("t1_cycles", 64'(cyc), 64'd4);

    // T2: WIDTH=2 with fault injection.
    begin_sweep(1, 1'b1, 1'b1);
    finish_sweep(1'b0, cyc);

    // T3: WIDTH=2 with random stalls.
    begin_sweep(1, 1'b0, 1'b1);
    finish_sweep(1'b1, cyc);

    // T4: reset after five rows, then a clean full sweep.
    begin_sweep(1, 1'b1, 1'b1);
    row_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("t4_reset");
    exp_q.delete();
    #3 rst_n = 1'b1;
    begin_sweep(1, 1'b0, 1'b1);
    finish_sweep(1'b0, cyc);

    // T5: start in RUN is ignored; start in DONE clears results and restarts.
    begin_sweep(1, 1'b1, 1'b1);
    row_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_sweep(1'b0, cyc);
    begin_sweep(1, 1'b0, 1'b1);
    chk("t5_restart_busy",  64'(o_busy[sel]),  64'd1);
    chk("t5_restart_done",  64'(o_done[sel]),  64'd0);
    chk("t5_restart_cnt",   64'(o_cnt[sel]),   64'd0);
    chk("t5_restart_ffv",   64'(o_ffv[sel]),   64'd0);
    chk("t5_restart_valid", 64'(o_valid[sel]), 64'd1);
    finish_sweep(1'b0, cyc);

    // T6: WIDTH=4 clean sweep, 256 cycles, ends on A=B=F.
    begin_sweep(2, 1'b0, 1'b1);
    finish_sweep(1'b0, cyc);
    chk("t6_cycles", 64'(cyc), 64'd256);
    chk("t6_last_a", 64'(o_a[sel]), 64'hF);
    chk("t6_last_b", 64'(o_b[sel]), 64'hF);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
